// File: rtl/doppler_nco_sched.sv
// Strobe sequencer and frequency-word configurator for doppler_nco: periodic nco_dv, Doppler rate ramp, boundary-aligned config.
// Optional output clamp with sticky freq_sat is compiled in by defining DOPPLER_SCHED_CLAMP_EN.
module doppler_nco_sched #(
  parameter int unsigned SAMPLE_DIV = 16,
  parameter int unsigned UPD_DIV    = 1024,
  parameter int unsigned RATE_W     = 24,
  parameter logic [31:0] FREQ_LIMIT = 32'h7FFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_freq,
  input  logic [RATE_W-1:0] cfg_rate,
  output logic              nco_dv,
  output logic [31:0]       nco_freq,
  output logic              freq_sat
);

  localparam int DIV_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int STEP_W = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(UPD_DIV - 1);
`ifdef DOPPLER_SCHED_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif
  localparam logic signed [32:0] LIM_HI = $signed({1'b0, FREQ_LIMIT});
  localparam logic signed [32:0] LIM_LO = -LIM_HI;

  // state  | meaning
  // IDLE   | no strobes, config loads directly
  // RUN    | strobing, no pending config
  // PEND   | strobing, shadow config waits for the next strobe
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                nco_dv_q, nco_dv_d;
  logic [31:0]         nco_freq_q, nco_freq_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic                freq_sat_q, freq_sat_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic [31:0]         shadow_freq_q, shadow_freq_d;
  logic [RATE_W-1:0]   shadow_rate_q, shadow_rate_d;

  logic                cfg_xfer;
  logic                div_wrap;
  logic signed [32:0]  freq_ext, rate_ext, sum;
  logic [31:0]         step_freq;
  logic                step_sat;

  assign cfg_xfer = cfg_valid & cfg_ready_q;
  assign div_wrap = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= '0;
      step_cnt_q    <= '0;
      nco_dv_q      <= 1'b0;
      nco_freq_q    <= '0;
      rate_q        <= '0;
      freq_sat_q    <= 1'b0;
      cfg_ready_q   <= 1'b1;
      shadow_freq_q <= '0;
      shadow_rate_q <= '0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      step_cnt_q    <= step_cnt_d;
      nco_dv_q      <= nco_dv_d;
      nco_freq_q    <= nco_freq_d;
      rate_q        <= rate_d;
      freq_sat_q    <= freq_sat_d;
      cfg_ready_q   <= cfg_ready_d;
      shadow_freq_q <= shadow_freq_d;
      shadow_rate_q <= shadow_rate_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN: begin
        if (!enable)       state_d = S_IDLE;
        else if (cfg_xfer) state_d = S_PEND;
      end
      S_PEND: begin
        if (!enable)       state_d = S_IDLE;
        else if (nco_dv_q) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Rate step in 33 bits so an overflow is visible to the optional clamp.
  always_comb begin
    freq_ext  = $signed({nco_freq_q[31], nco_freq_q});
    rate_ext  = $signed({{(33 - RATE_W){rate_q[RATE_W-1]}}, rate_q});
    sum       = freq_ext + rate_ext;
    step_freq = sum[31:0];
    step_sat  = 1'b0;
    if (CLAMP_EN) begin
      if (sum > LIM_HI) begin
        step_freq = LIM_HI[31:0];
        step_sat  = 1'b1;
      end else if (sum < LIM_LO) begin
        step_freq = LIM_LO[31:0];
        step_sat  = 1'b1;
      end
    end
  end

  // Frequency updates land on the edge that ends the strobe cycle, so nco_freq is stable while nco_dv is high.
  always_comb begin
    div_cnt_d     = div_cnt_q;
    step_cnt_d    = step_cnt_q;
    nco_dv_d      = 1'b0;
    nco_freq_d    = nco_freq_q;
    rate_d        = rate_q;
    freq_sat_d    = freq_sat_q;
    shadow_freq_d = shadow_freq_q;
    shadow_rate_d = shadow_rate_q;
    cfg_ready_d   = (state_d != S_PEND);
    case (state_q)
      S_IDLE: begin
        div_cnt_d  = '0;
        step_cnt_d = '0;
        if (cfg_xfer) begin
          nco_freq_d = cfg_freq;
          rate_d     = cfg_rate;
          freq_sat_d = 1'b0;
        end
      end
      S_RUN, S_PEND: begin
        if (!enable) begin
          div_cnt_d  = '0;
          step_cnt_d = '0;
          if (state_q == S_PEND) begin
            nco_freq_d = shadow_freq_q;
            rate_d     = shadow_rate_q;
            freq_sat_d = 1'b0;
          end else if (cfg_xfer) begin
            nco_freq_d = cfg_freq;
            rate_d     = cfg_rate;
            freq_sat_d = 1'b0;
          end
        end else begin
          nco_dv_d  = div_wrap;
          div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
          if (nco_dv_q) begin
            if (state_q == S_PEND) begin
              nco_freq_d = shadow_freq_q;
              rate_d     = shadow_rate_q;
              freq_sat_d = 1'b0;
              step_cnt_d = '0;
            end else if (step_cnt_q == STEP_LAST) begin
              step_cnt_d = '0;
              nco_freq_d = step_freq;
              freq_sat_d = freq_sat_q | step_sat;
            end else begin
              step_cnt_d = step_cnt_q + 1'b1;
            end
          end
          if (state_q == S_RUN && cfg_xfer) begin
            shadow_freq_d = cfg_freq;
            shadow_rate_d = cfg_rate;
          end
        end
      end
      default: ;
    endcase
  end

  assign cfg_ready = cfg_ready_q;
  assign nco_dv    = nco_dv_q;
  assign nco_freq  = nco_freq_q;
  assign freq_sat  = freq_sat_q;

endmodule

// File: tb/tb_doppler_nco_sched.sv
// Bench for doppler_nco_sched: table of ramp vectors, scoreboard of per-strobe freq words, hand sequences for config/disable/reset.
module tb_doppler_nco_sched;
  localparam int SD = 16;
  localparam int UD = 4;
  localparam int RW = 24;

  logic          clk = 1'b0;
  logic          reset, enable, cfg_valid, cfg_ready, nco_dv, freq_sat;
  logic [31:0]   cfg_freq, nco_freq;
  logic [RW-1:0] cfg_rate;

  always #5 clk = ~clk;

  doppler_nco_sched #(.SAMPLE_DIV(SD), .UPD_DIV(UD), .RATE_W(RW), .FREQ_LIMIT(32'h7FFFFFFF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_freq(cfg_freq), .cfg_rate(cfg_rate), .nco_dv(nco_dv), .nco_freq(nco_freq), .freq_sat(freq_sat)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  logic [31:0]   m_freq, m_sh_freq;
  logic [RW-1:0] m_rate, m_sh_rate;
  int            m_step;
  bit            m_pend, m_sat;

  typedef struct {
    logic [31:0]   freq;
    logic [RW-1:0] rate;
    int            n;
    logic [31:0]   exp_freq;
    logic          exp_sat;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] step_fn(input logic [31:0] f, input logic [RW-1:0] r, output bit sat);
    longint s;
    s   = longint'($signed(f)) + longint'($signed(r));
    sat = 1'b0;
`ifdef DOPPLER_SCHED_CLAMP_EN
    if (s > 64'sh7FFFFFFF) begin sat = 1'b1; return 32'h7FFFFFFF; end
    if (s < -64'sh7FFFFFFF) begin sat = 1'b1; return 32'h80000001; end
`endif
    return s[31:0];
  endfunction

  // Each strobe must show the freq word the model predicted for it.
  always @(negedge clk) begin
    if (!reset && nco_dv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got nco_dv=1 expected 0 at %0t", $time);
      end else begin
        chk("strobe_freq", nco_freq, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_strobe();
    bit s;
    exp_q.push_back(m_freq);
    if (m_pend) begin
      m_freq = m_sh_freq; m_rate = m_sh_rate; m_step = 0; m_pend = 0; m_sat = 0;
    end else begin
      m_step++;
      if (m_step == UD) begin
        m_step = 0;
        m_freq = step_fn(m_freq, m_rate, s);
        m_sat  = m_sat | s;
      end
    end
  endtask

  task automatic next_strobe(input string name, output int gap);
    model_strobe();
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!nco_dv && gap < 100);
    if (!nco_dv) begin
      checks++;
      errors++;
      $display("FAIL %s: got no strobe in %0d cycles expected one", name, gap);
      exp_q.delete();
    end
  endtask

  task automatic cfg_idle(input logic [31:0] f, input logic [RW-1:0] r);
    cfg_valid = 1'b1; cfg_freq = f; cfg_rate = r;
    tick();
    cfg_valid = 1'b0;
    m_freq = f; m_rate = r; m_sat = 0; m_step = 0;
    chk("idle_load_freq", nco_freq, f);
    chk("idle_load_sat", {31'd0, freq_sat}, 32'd0);
  endtask

  task automatic cfg_run(input logic [31:0] f, input logic [RW-1:0] r);
    cfg_valid = 1'b1; cfg_freq = f; cfg_rate = r;
    tick();
    cfg_valid = 1'b0;
    m_sh_freq = f; m_sh_rate = r; m_pend = 1;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
    m_step = 0;
  endtask

  task automatic stop();
    enable = 1'b0;
    tick();
    m_step = 0;
    if (m_pend) begin
      m_freq = m_sh_freq; m_rate = m_sh_rate; m_pend = 0; m_sat = 0;
    end
  endtask

  task automatic quiet(input string name, input int n);
    int seen = 0;
    repeat (n) begin
      tick();
      if (nco_dv) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int gap;
    tbl[0] = '{32'h01234567, 24'h000100, 4, 32'h01234667, 1'b0};
    tbl[1] = '{32'h01234567, 24'h000100, 8, 32'h01234767, 1'b0};
    tbl[2] = '{32'h00000010, 24'hFFFFFF, 4, 32'h0000000F, 1'b0};
    tbl[3] = '{32'h00000000, 24'hFFFFF0, 8, 32'hFFFFFFE0, 1'b0};
`ifdef DOPPLER_SCHED_CLAMP_EN
    tbl[4] = '{32'h7FFFFF80, 24'h000100, 4, 32'h7FFFFFFF, 1'b1};
    tbl[5] = '{32'h80000010, 24'hFFFFE0, 4, 32'h80000001, 1'b1};
`else
    tbl[4] = '{32'h7FFFFF80, 24'h000100, 4, 32'h80000080, 1'b0};
    tbl[5] = '{32'h80000010, 24'hFFFFE0, 4, 32'h7FFFFFF0, 1'b0};
`endif
    tbl[6] = '{32'h00000005, 24'h7FFFFF, 4, 32'h00800004, 1'b0};

    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_freq = '0; cfg_rate = '0;
    m_freq = '0; m_rate = '0; m_step = 0; m_pend = 0; m_sat = 0; m_sh_freq = '0; m_sh_rate = '0;
    repeat (10) tick();
    reset = 1'b0;
    chk("rst_dv", {31'd0, nco_dv}, 32'd0);
    chk("rst_freq", nco_freq, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_sat", {31'd0, freq_sat}, 32'd0);
    quiet("rst_idle_quiet", 20);

    // Constant freq, strobe cadence over 1000 strobes.
    cfg_idle(32'h01234567, 24'h000000);
    start();
    for (int i = 0; i < 1000; i++) begin
      next_strobe("t1_strobe", gap);
      chk("t1_gap", gap, SD);
    end
    tick();
    chk("t1_freq_end", nco_freq, 32'h01234567);
    stop();

    // Ramp vectors, including wrap/clamp at the signed boundary.
    for (int v = 0; v < 7; v++) begin
      cfg_idle(tbl[v].freq, tbl[v].rate);
      start();
      for (int k = 0; k < tbl[v].n; k++) begin
        next_strobe("tbl_strobe", gap);
        chk("tbl_gap", gap, SD);
      end
      tick();
      chk("tbl_freq", nco_freq, tbl[v].exp_freq);
      chk("tbl_sat", {31'd0, freq_sat}, {31'd0, tbl[v].exp_sat});
      stop();
    end

    // Config in RUN applies on the next strobe and restarts the step count.
    cfg_idle(32'h01234567, 24'h000100);
    start();
    next_strobe("t3_s1", gap);
    repeat (5) tick();
    cfg_run(32'h04468ace, 24'h000100);
    chk("t3_ready_low", {31'd0, cfg_ready}, 32'd0);
    next_strobe("t3_apply", gap);
    chk("t3_ready_at_strobe", {31'd0, cfg_ready}, 32'd0);
    tick();
    chk("t3_ready_high", {31'd0, cfg_ready}, 32'd1);
    chk("t3_freq_applied", nco_freq, 32'h04468ace);
    for (int k = 0; k < UD; k++) next_strobe("t3_post", gap);
    tick();
    chk("t3_freq_stepped", nco_freq, 32'h04468bce);
    stop();

    // Config apply on a rate-step strobe: config wins.
    cfg_idle(32'h01234567, 24'h000100);
    start();
    for (int k = 0; k < UD - 1; k++) next_strobe("t4_pre", gap);
    repeat (4) tick();
    cfg_run(32'h0A0B0C0D, 24'h000010);
    next_strobe("t4_apply", gap);
    tick();
    chk("t4_freq_no_step", nco_freq, 32'h0A0B0C0D);
    for (int k = 0; k < UD; k++) next_strobe("t4_post", gap);
    tick();
    chk("t4_freq_stepped", nco_freq, 32'h0A0B0C1D);
    stop();

    // Disable mid-interval in RUN.
    cfg_idle(32'h00ABCDEF, 24'h000010);
    start();
    next_strobe("t6_s1", gap);
    repeat (3) tick();
    stop();
    quiet("t6_disable_quiet", 40);
    chk("t6_disable_freq", nco_freq, 32'h00ABCDEF);
    chk("t6_disable_ready", {31'd0, cfg_ready}, 32'd1);

    // Disable in PEND applies the shadow config at once.
    start();
    next_strobe("t6_s2", gap);
    chk("t6_regap", gap, SD);
    repeat (2) tick();
    cfg_run(32'h00112233, 24'h000020);
    chk("t6_pend_ready", {31'd0, cfg_ready}, 32'd0);
    stop();
    chk("t6_pend_disable_freq", nco_freq, 32'h00112233);
    chk("t6_pend_disable_ready", {31'd0, cfg_ready}, 32'd1);
    quiet("t6_pend_quiet", 20);

    // Reset mid-PEND.
    start();
    next_strobe("t6_s3", gap);
    repeat (3) tick();
    cfg_run(32'h0F0F0F0F, 24'h000005);
    enable = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    m_freq = '0; m_rate = '0; m_pend = 0; m_step = 0; m_sat = 0;
    chk("t6_rst_freq", nco_freq, 32'd0);
    chk("t6_rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("t6_rst_dv", {31'd0, nco_dv}, 32'd0);
    quiet("t6_rst_quiet", 40);
    chk("t6_rst_freq_held", nco_freq, 32'd0);
    start();
    next_strobe("t6_reen", gap);
    chk("t6_reen_gap", gap, SD);
    stop();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
